// File: rtl/axi_fifo_wr_master.sv
// rtl/axi_fifo_wr_master.sv - drains a FWFT FIFO onto AXI4 INCR write bursts, 4 KB safe
module axi_fifo_wr_master #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int ID_W      = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [15:0]         cmd_len_i,
   output logic                done_o,
   output logic                err_o,
   output logic                fifo_rd_en_o,
   input  logic [DATA_W-1:0]   fifo_dout_i,
   input  logic                fifo_empty_i,
   output logic [ID_W-1:0]     awid_o,
   output logic [ADDR_W-1:0]   awaddr_o,
   output logic [7:0]          awlen_o,
   output logic [2:0]          awsize_o,
   output logic [1:0]          awburst_o,
   output logic                awvalid_o,
   input  logic                awready_i,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wstrb_o,
   output logic                wlast_o,
   output logic                wvalid_o,
   input  logic                wready_i,
   input  logic [ID_W-1:0]     bid_i,
   input  logic [1:0]          bresp_i,
   input  logic                bvalid_i,
   output logic                bready_o
);
   localparam int BPB  = DATA_W / 8;
   localparam int SIZE = $clog2(BPB);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       rem_q, rem_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [7:0]        awlen_q, awlen_d;
   logic [8:0]        blen_q, blen_d;
   logic [7:0]        beat_q, beat_d;
   logic              err_q, err_d;

   logic [12:0] page_room, page_beats;
   logic [16:0] blen_c;
   logic        unused_bid;

   assign unused_bid = ^bid_i;

   // beats left before the next 4 KB page boundary; addr is beat aligned so this is >= 1
   assign page_room  = 13'd4096 - {1'b0, addr_q[11:0]};
   assign page_beats = page_room >> SIZE;

   always_comb begin
      blen_c = {1'b0, rem_q};
      if (blen_c > 17'(MAX_BURST)) blen_c = 17'(MAX_BURST);
      if (blen_c > {4'b0, page_beats}) blen_c = {4'b0, page_beats};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         awaddr_q <= '0;
         awlen_q  <= '0;
         blen_q   <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         awaddr_q <= awaddr_d;
         awlen_q  <= awlen_d;
         blen_q   <= blen_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      awaddr_d = awaddr_q;
      awlen_d  = awlen_q;
      blen_d   = blen_q;
      beat_d   = beat_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_i;
               rem_d   = cmd_len_i;
               err_d   = 1'b0;
               state_d = (cmd_len_i == 16'd0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            blen_d   = 9'(blen_c);
            awaddr_d = addr_q;
            awlen_d  = 8'(blen_c - 17'd1);
            state_d  = S_AW;
         end
         S_AW: begin
            if (awready_i) begin
               beat_d  = 8'd0;
               state_d = S_W;
            end
         end
         S_W: begin
            if (wvalid_o && wready_i) begin
               if (wlast_o) state_d = S_B;
               else         beat_d  = beat_q + 8'd1;
            end
         end
         S_B: begin
            if (bvalid_i) begin
               err_d   = err_q | (bresp_i != 2'b00);
               addr_d  = addr_q + (ADDR_W'(blen_q) << SIZE);
               rem_d   = rem_q - 16'(blen_q);
               state_d = (rem_q == 16'(blen_q)) ? S_DONE : S_CALC;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // W channel is a straight combinational pass-through of the FIFO head
   always_comb begin
      cmd_ready_o  = (state_q == S_IDLE);
      done_o       = (state_q == S_DONE);
      err_o        = err_q;
      awid_o       = '0;
      awaddr_o     = awaddr_q;
      awlen_o      = awlen_q;
      awsize_o     = 3'(SIZE);
      awburst_o    = 2'b01;
      awvalid_o    = (state_q == S_AW);
      wdata_o      = fifo_dout_i;
      wstrb_o      = '1;
      wvalid_o     = (state_q == S_W) && !fifo_empty_i;
      wlast_o      = (state_q == S_W) && (beat_q == awlen_q);
      fifo_rd_en_o = wvalid_o && wready_i;
      bready_o     = (state_q == S_B);
   end
endmodule
